// File: rtl/uart_host_port.sv
`default_nettype none
// ============================================================================
//  Module   : uart_host_port
//  Purpose  : Byte-wide host bridge for a UART-style design port. Bytes the
//             design strobes out on txclk are paced and queued in an up-FIFO
//             for the host. Bytes the host pushes are queued in a down-FIFO
//             and handed to the design, one per rxclk strobe.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    hz100      in   1  clock (all state on rising edge)
//    reset      in   1  asynchronous active-high reset
//    txdata     in   8  byte offered by the design
//    txclk      in   1  transmit strobe, rising edge offers txdata
//    txready    out  1  a byte can be accepted
//    rxdata     out  8  down-FIFO head presented to the design
//    rxclk      in   1  receive acknowledge, rising edge consumes rxdata
//    rxready    out  1  rxdata valid
//    h_rx_data  out  8  up-FIFO head presented to the host
//    h_rx_valid out  1  up-FIFO non-empty
//    h_rx_pop   in   1  host removes up-FIFO head
//    h_tx_data  in   8  host byte toward the design
//    h_tx_push  in   1  append h_tx_data to down-FIFO
//    h_tx_full  out  1  down-FIFO full
//    overrun    out  1  sticky: txclk edge seen while txready was low
// ============================================================================
module uart_host_port #(
    parameter int DEPTH       = 4,
    parameter int BYTE_CYCLES = 10
) (
    input  logic       hz100,
    input  logic       reset,
    input  logic [7:0] txdata,
    input  logic       txclk,
    output logic       txready,
    output logic [7:0] rxdata,
    input  logic       rxclk,
    output logic       rxready,
    output logic [7:0] h_rx_data,
    output logic       h_rx_valid,
    input  logic       h_rx_pop,
    input  logic [7:0] h_tx_data,
    input  logic       h_tx_push,
    output logic       h_tx_full,
    output logic       overrun
);

    localparam int c_PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_BUSY_W = $clog2(BYTE_CYCLES + 1);

    localparam logic [c_CNT_W-1:0]  c_FULL     = c_CNT_W'(DEPTH);
    localparam logic [c_BUSY_W-1:0] c_BUSY_LD  = c_BUSY_W'(BYTE_CYCLES);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_BUSY_W-1:0] c_BUSY_ONE = c_BUSY_W'(1);

    // Strobe history; reset high so a strobe held across reset release
    // does not look like a fresh edge.
    logic r_txclk_q;
    logic r_rxclk_q;

    // Up-FIFO (design -> host)
    logic [7:0]         r_up_mem [DEPTH];
    logic [c_PTR_W-1:0] r_up_wptr;
    logic [c_PTR_W-1:0] r_up_rptr;
    logic [c_CNT_W-1:0] r_up_cnt;

    // Down-FIFO (host -> design)
    logic [7:0]         r_dn_mem [DEPTH];
    logic [c_PTR_W-1:0] r_dn_wptr;
    logic [c_PTR_W-1:0] r_dn_rptr;
    logic [c_CNT_W-1:0] r_dn_cnt;

    logic [c_BUSY_W-1:0] r_busy;
    logic                r_txready;
    logic                r_overrun;

    logic                w_tx_edge;
    logic                w_rx_edge;
    logic                w_up_wr;
    logic                w_up_rd;
    logic                w_dn_wr;
    logic                w_dn_rd;
    logic                w_dn_full;
    logic [c_CNT_W-1:0]  w_up_cnt_nxt;
    logic [c_CNT_W-1:0]  w_dn_cnt_nxt;
    logic [c_BUSY_W-1:0] w_busy_nxt;
    logic                w_txready_nxt;

    assign w_tx_edge = txclk & ~r_txclk_q;
    assign w_rx_edge = rxclk & ~r_rxclk_q;

    // r_txready already implies the up-FIFO has room.
    assign w_up_wr   = w_tx_edge & r_txready;
    assign w_up_rd   = h_rx_pop & (r_up_cnt != '0);

    // A full down-FIFO still takes a push when the head leaves that cycle.
    assign w_dn_full = (r_dn_cnt == c_FULL);
    assign w_dn_rd   = w_rx_edge & (r_dn_cnt != '0);
    assign w_dn_wr   = h_tx_push & (~w_dn_full | w_dn_rd);

    always_comb begin
        w_up_cnt_nxt = r_up_cnt;
        if (w_up_wr && !w_up_rd) begin
            w_up_cnt_nxt = r_up_cnt + c_CNT_ONE;
        end else if (!w_up_wr && w_up_rd) begin
            w_up_cnt_nxt = r_up_cnt - c_CNT_ONE;
        end

        w_dn_cnt_nxt = r_dn_cnt;
        if (w_dn_wr && !w_dn_rd) begin
            w_dn_cnt_nxt = r_dn_cnt + c_CNT_ONE;
        end else if (!w_dn_wr && w_dn_rd) begin
            w_dn_cnt_nxt = r_dn_cnt - c_CNT_ONE;
        end

        w_busy_nxt = r_busy;
        if (w_up_wr) begin
            w_busy_nxt = c_BUSY_LD;
        end else if (r_busy != '0) begin
            w_busy_nxt = r_busy - c_BUSY_ONE;
        end

        // Registered from next-state values so txready tracks the busy
        // counter and occupancy without an extra cycle of lag.
        w_txready_nxt = (w_busy_nxt == '0) && (w_up_cnt_nxt != c_FULL);
    end

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            r_txclk_q <= 1'b1;
            r_rxclk_q <= 1'b1;
            r_up_wptr <= '0;
            r_up_rptr <= '0;
            r_up_cnt  <= '0;
            r_dn_wptr <= '0;
            r_dn_rptr <= '0;
            r_dn_cnt  <= '0;
            r_busy    <= '0;
            r_txready <= 1'b1;
            r_overrun <= 1'b0;
        end else begin
            r_txclk_q <= txclk;
            r_rxclk_q <= rxclk;
            if (w_up_wr) begin
                r_up_wptr <= r_up_wptr + c_PTR_ONE;
            end
            if (w_up_rd) begin
                r_up_rptr <= r_up_rptr + c_PTR_ONE;
            end
            if (w_dn_wr) begin
                r_dn_wptr <= r_dn_wptr + c_PTR_ONE;
            end
            if (w_dn_rd) begin
                r_dn_rptr <= r_dn_rptr + c_PTR_ONE;
            end
            r_up_cnt  <= w_up_cnt_nxt;
            r_dn_cnt  <= w_dn_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_txready <= w_txready_nxt;
            if (w_tx_edge && !r_txready) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Storage carries no reset; outputs are masked while a FIFO is empty.
    always_ff @(posedge hz100) begin
        if (w_up_wr) begin
            r_up_mem[r_up_wptr] <= txdata;
        end
        if (w_dn_wr) begin
            r_dn_mem[r_dn_wptr] <= h_tx_data;
        end
    end

    assign txready    = r_txready;
    assign overrun    = r_overrun;
    assign h_rx_valid = (r_up_cnt != '0);
    assign h_rx_data  = h_rx_valid ? r_up_mem[r_up_rptr] : 8'h00;
    assign rxready    = (r_dn_cnt != '0);
    assign rxdata     = rxready ? r_dn_mem[r_dn_rptr] : 8'h00;
    assign h_tx_full  = w_dn_full;

endmodule
`default_nettype wire
